pipeline_sequencer: RTL and testbench
=====================================

# pipeline_sequencer

Controls the timing of the MIPS pipeline stages (IF/ID/EX/MEM/WB) for the debug unit. It generates the global `o_enable_pipeline` and per-stage `o_enable_etapa` strobes in continuous mode or single-step mode. On a load-use hazard it holds the PC and inserts a bubble, and it drains the pipeline after a HALT so the last instruction retires before the debug unit is notified. It sits between the debug/UART unit and every stage top, and owns the PC write enable and the executed-cycle counter.

## Interface
- `PIPELINE_DEPTH`, 5, number of stages; a HALT fetched in IF needs `PIPELINE_DEPTH-1` advancing cycles to reach WB.
- `CANT_BITS_CONTADOR`, 32, width of the executed-cycle counter.
- `CANT_BITS_DRAIN`, 3, width of the drain down-counter; must satisfy 2^N > `PIPELINE_DEPTH-1`.
- `i_clock` in 1: single clock; all state updates on the rising edge.
- `i_soft_reset` in 1: synchronous, active-low reset.
- `i_start` in 1: one-cycle pulse from the debug unit that begins a program run; sampled only in IDLE.
- `i_mode_step` in 1: 1 = step mode, 0 = continuous; sampled only with `i_start` in IDLE.
- `i_step` in 1: one-cycle pulse that advances exactly one cycle; honoured only in STEP_WAIT.
- `i_halt_detected` in 1: the instruction currently in IF is HALT.
- `i_load_use_hazard` in 1: load-use hazard indication from the hazard detection logic.
- `i_debug_ack` in 1: debug unit has read the results; honoured only in DONE.
- `o_enable_pipeline` out 1: pipeline registers advance this cycle.
- `o_enable_etapa` out 1: stage combinational enables; identical to `o_enable_pipeline`.
- `o_enable_pc` out 1: PC register write enable.
- `o_bubble` out 1: ID/EX control signals are forced to zero this cycle.
- `o_done` out 1: level signal; high while in DONE.
- `o_cycle_count` out `CANT_BITS_CONTADOR`: number of advancing cycles since the last accepted `i_start`.
- `o_state` out 3: current state, IDLE=0, RUN=1, STEP_WAIT=2, STEP_EXEC=3, DRAIN=4, DONE=5.

## Operation
- **adv** (advancing cycle) = state is RUN, STEP_EXEC or DRAIN.
- **Enable outputs**, decoded combinationally from the state register:
  - `o_enable_pipeline` = `o_enable_etapa` = adv.
  - `o_enable_pc` = adv & ~`i_load_use_hazard` & ~draining.
  - `o_bubble` = adv & `i_load_use_hazard`.
- **draining**: an internal flag, high from HALT acceptance until DONE. It is also implied whenever the state is DRAIN.
- **HALT acceptance**: HALT is accepted only when `i_halt_detected` & `o_enable_pc`. A HALT stalled by a hazard is not accepted until the cycle in which it actually leaves IF.
  - On acceptance, the drain counter loads `PIPELINE_DEPTH-1` and the draining flag is set.
- **Drain counter**: decrements on every adv cycle while draining, including bubble cycles.
- **State transitions**:
  - IDLE: on `i_start`, clear `o_cycle_count`, then go to STEP_WAIT if `i_mode_step`, else RUN.
  - RUN: on HALT acceptance go to DRAIN; otherwise stay in RUN.
  - DRAIN: go to DONE on the adv cycle where the drain counter equals 1; otherwise stay in DRAIN.
  - STEP_WAIT: on `i_step` go to STEP_EXEC; other inputs are ignored.
  - STEP_EXEC (exactly one cycle):
    - If draining and the drain counter equals 1, go to DONE.
    - Otherwise go to STEP_WAIT. A HALT accepted in this cycle loads the counter and sets draining.
    - In step mode the drain therefore consumes `PIPELINE_DEPTH-1` further `i_step` pulses.
  - DONE: all enables low. On `i_debug_ack`, go to IDLE and clear draining. `o_cycle_count` holds its value.
- **`o_cycle_count`**: increments on every adv cycle and saturates at all-ones with no wrap.
- **Ignored inputs**:
  - `i_step` outside STEP_WAIT.
  - `i_start` outside IDLE.
  - `i_debug_ack` outside DONE.
  - `i_mode_step` changes outside IDLE.
- **Reset** (`i_soft_reset`=0 at a rising edge, including mid-run or mid-drain): state goes to IDLE; drain counter, draining flag and `o_cycle_count` go to 0.
- **Outputs during reset and in IDLE**: all enables 0, `o_bubble` 0, `o_done` 0, `o_state` 0.

## Timing
- `i_start` sampled high at edge N: state is RUN after edge N; the first adv cycle is N→N+1.
- `i_step` sampled at edge N: exactly one adv cycle, N→N+1. A new `i_step` is honoured at edge N+2 at the earliest.
- Continuous run, HALT accepted in the cycle ending at edge N: DRAIN lasts `PIPELINE_DEPTH-1` adv cycles; state is DONE after edge N+4 (default depth).
- Hazard gating is combinational. `o_bubble` and `o_enable_pc` respond in the same cycle as `i_load_use_hazard`.
- Simultaneous `i_halt_detected` and `i_load_use_hazard`: the hazard wins; HALT is not accepted that cycle.
- `i_debug_ack` sampled at edge N in DONE: IDLE after N. The same-cycle `i_start` is ignored; the next `i_start` is accepted at edge N+1 or later.

## Test plan
- **Continuous run**: reset, `i_start` with `i_mode_step`=0, `i_halt_detected` pulsed on the 10th adv cycle.
  - Required: 10 RUN cycles plus 4 DRAIN cycles, then `o_done`=1 and `o_cycle_count`=14.
  - Required: `o_enable_pc`=0 throughout DRAIN.
- **Load-use hazard**: in RUN, raise `i_load_use_hazard` for 1 cycle.
  - Required: in that cycle `o_enable_pc`=0, `o_bubble`=1, `o_enable_pipeline`=1; counter still increments.
  - Then raise the hazard and `i_halt_detected` together: HALT is not accepted until the cycle after the hazard clears.
- **Step mode**: `i_start` with `i_mode_step`=1, 3 `i_step` pulses spaced 5 cycles apart.
  - Required: exactly 3 single-cycle enable pulses and `o_cycle_count`=3.
  - Required: an `i_step` held high for 2 cycles yields one advance only.
- **Step mode drain**: HALT accepted in a STEP_EXEC cycle.
  - Required: state goes to DONE after the 4th subsequent `i_step`, not before.
- **Reset mid-drain**: `i_soft_reset`=0 for one edge during DRAIN.
  - Required: IDLE, all outputs 0, `o_cycle_count`=0.
  - Required: a following `i_start` yields a normal run.
- **Saturation and ack**: `CANT_BITS_CONTADOR`=4, run 20 cycles before HALT.
  - Required: `o_cycle_count` holds at 15.
  - `i_debug_ack` in DONE → IDLE, `o_done`=0, count held at 15 until the next `i_start`.

Source files
------------

// File: rtl/pipeline_sequencer.sv
// Pipeline stage sequencer for the debug unit: continuous/step advance,
// load-use bubble insertion and post-HALT drain before reporting DONE.
module pipeline_sequencer #(
  parameter int PIPELINE_DEPTH     = 5,
  parameter int CANT_BITS_CONTADOR = 32,
  parameter int CANT_BITS_DRAIN    = 3
) (
  input  logic                          i_clock,
  input  logic                          i_soft_reset,
  input  logic                          i_start,
  input  logic                          i_mode_step,
  input  logic                          i_step,
  input  logic                          i_halt_detected,
  input  logic                          i_load_use_hazard,
  input  logic                          i_debug_ack,
  output logic                          o_enable_pipeline,
  output logic                          o_enable_etapa,
  output logic                          o_enable_pc,
  output logic                          o_bubble,
  output logic                          o_done,
  output logic [CANT_BITS_CONTADOR-1:0] o_cycle_count,
  output logic [2:0]                    o_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    STEP_WAIT = 3'd2,
    STEP_EXEC = 3'd3,
    DRAIN     = 3'd4,
    DONE      = 3'd5
  } state_t;

  localparam logic [CANT_BITS_DRAIN-1:0]    DRAIN_LOAD = CANT_BITS_DRAIN'(PIPELINE_DEPTH - 1);
  localparam logic [CANT_BITS_DRAIN-1:0]    DRAIN_ONE  = CANT_BITS_DRAIN'(1);
  localparam logic [CANT_BITS_CONTADOR-1:0] CNT_ONE    = CANT_BITS_CONTADOR'(1);

  state_t                      state;
  logic [CANT_BITS_DRAIN-1:0]  drain_cnt;
  logic                        draining;
  logic                        drain_active;
  logic                        adv;
  logic                        halt_acc;
  logic                        drain_last;

  assign adv          = (state == RUN) || (state == STEP_EXEC) || (state == DRAIN);
  assign drain_active = draining || (state == DRAIN);
  assign drain_last   = drain_active && (drain_cnt == DRAIN_ONE);

  // Hazard gating is purely combinational so the PC freezes in the same cycle.
  assign o_enable_pipeline = adv;
  assign o_enable_etapa    = adv;
  assign o_enable_pc       = adv && !i_load_use_hazard && !drain_active;
  assign o_bubble          = adv && i_load_use_hazard;
  assign o_done            = (state == DONE);
  assign o_state           = state;

  // A HALT held in IF by a hazard only counts once it actually leaves IF.
  assign halt_acc = i_halt_detected && o_enable_pc;

  always_ff @(posedge i_clock) begin
    if (!i_soft_reset) begin
      state         <= IDLE;
      drain_cnt     <= '0;
      draining      <= 1'b0;
      o_cycle_count <= '0;
    end else begin
      if (adv && (o_cycle_count != '1))
        o_cycle_count <= o_cycle_count + CNT_ONE;

      if (halt_acc) begin
        drain_cnt <= DRAIN_LOAD;
        draining  <= 1'b1;
      end else if (adv && drain_active && (drain_cnt != '0)) begin
        drain_cnt <= drain_cnt - DRAIN_ONE;
      end

      case (state)
        IDLE: if (i_start) begin
          o_cycle_count <= '0;
          state         <= i_mode_step ? STEP_WAIT : RUN;
        end
        RUN:       if (halt_acc) state <= DRAIN;
        DRAIN:     if (drain_last) state <= DONE;
        STEP_WAIT: if (i_step) state <= STEP_EXEC;
        STEP_EXEC: state <= drain_last ? DONE : STEP_WAIT;
        DONE: if (i_debug_ack) begin
          state    <= IDLE;
          draining <= 1'b0;
        end
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench: per-cycle expectations queued by stimulus, popped by
// monitors on every advancing cycle and on each rising o_done.
module tb_pipeline_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, mode_step, step, halt, haz, ack;
  logic        en_pipe, en_etapa, en_pc, bubble, done;
  logic [31:0] cnt;
  logic [2:0]  state;
  logic        s_en_pipe, s_en_etapa, s_en_pc, s_bubble, s_done;
  logic [3:0]  s_cnt;
  logic [2:0]  s_state;

  always #5 clk = ~clk;

  pipeline_sequencer dut (
    .i_clock(clk), .i_soft_reset(rst), .i_start(start), .i_mode_step(mode_step),
    .i_step(step), .i_halt_detected(halt), .i_load_use_hazard(haz), .i_debug_ack(ack),
    .o_enable_pipeline(en_pipe), .o_enable_etapa(en_etapa), .o_enable_pc(en_pc),
    .o_bubble(bubble), .o_done(done), .o_cycle_count(cnt), .o_state(state)
  );

  pipeline_sequencer #(.CANT_BITS_CONTADOR(4)) dut_sat (
    .i_clock(clk), .i_soft_reset(rst), .i_start(start), .i_mode_step(mode_step),
    .i_step(step), .i_halt_detected(halt), .i_load_use_hazard(haz), .i_debug_ack(ack),
    .o_enable_pipeline(s_en_pipe), .o_enable_etapa(s_en_etapa), .o_enable_pc(s_en_pc),
    .o_bubble(s_bubble), .o_done(s_done), .o_cycle_count(s_cnt), .o_state(s_state)
  );

  typedef struct { logic pc; logic bub; int unsigned cnt; } exp_t;
  exp_t        adv_q[$];
  int unsigned done_q[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned m_cnt  = 0;
  logic        done_prev = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advancing-cycle monitor
  always @(negedge clk) begin
    if (en_pipe === 1'b1) begin
      if (adv_q.size() == 0) begin
        chk("unexpected_adv", 1, 0);
      end else begin
        exp_t e;
        e = adv_q.pop_front();
        chk("adv_enable_pc", en_pc, e.pc);
        chk("adv_bubble", bubble, e.bub);
        chk("adv_etapa", en_etapa, 1);
        chk("adv_count", cnt, e.cnt);
      end
    end
  end

  // Completion monitor
  always @(negedge clk) begin
    if (done === 1'b1 && !done_prev) begin
      if (done_q.size() == 0) chk("unexpected_done", 1, 0);
      else chk("done_count", cnt, done_q.pop_front());
    end
    done_prev = (done === 1'b1);
  end

  task automatic cyc(input logic st, md, stp, hlt, hz, ak, input logic adv, pc, bub);
    start = st; mode_step = md; step = stp; halt = hlt; haz = hz; ack = ak;
    if (adv) begin
      adv_q.push_back('{pc, bub, m_cnt});
      m_cnt++;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 1, 1, 0);
  endtask

  task automatic drain_n(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic go(input logic md);
    cyc(1, md, 0, 0, 0, 0, 0, 0, 0);
    m_cnt = 0;
  endtask

  initial begin
    rst = 1'b0;
    start = 0; mode_step = 0; step = 0; halt = 0; haz = 0; ack = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_state", state, 0);
    chk("rst_en_pipe", en_pipe, 0);
    chk("rst_en_pc", en_pc, 0);
    chk("rst_bubble", bubble, 0);
    chk("rst_done", done, 0);
    chk("rst_count", cnt, 0);
    rst = 1'b1;

    // Continuous run: HALT on the 10th adv cycle, 4 drain cycles
    go(0);
    chk("run_state", state, 1);
    run_n(9);
    done_q.push_back(14);
    cyc(0, 0, 0, 1, 0, 0, 1, 1, 0);
    chk("drain_state", state, 4);
    drain_n(4);
    chk("done_state", state, 5);
    chk("done_level", done, 1);
    chk("done_count14", cnt, 14);
    chk("done_en_pipe", en_pipe, 0);
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 0);   // ack with same-cycle start: start ignored
    chk("ack_state", state, 0);
    chk("ack_done", done, 0);
    chk("ack_count_held", cnt, 14);
    idle(1);
    chk("start_ignored", state, 0);

    // Load-use hazard, then hazard together with HALT
    go(0);
    run_n(2);
    cyc(0, 0, 0, 0, 1, 0, 1, 0, 1);
    run_n(1);
    cyc(0, 0, 0, 1, 1, 0, 1, 0, 1);
    chk("halt_blocked", state, 1);
    done_q.push_back(10);
    cyc(0, 0, 0, 1, 0, 0, 1, 1, 0);
    chk("halt_after_haz", state, 4);
    cyc(0, 0, 0, 0, 1, 0, 1, 0, 1);   // bubble during drain still counts
    drain_n(3);
    chk("haz_done_state", state, 5);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);

    // Step mode: three spaced pulses
    go(1);
    chk("step_wait_state", state, 2);
    for (int p = 0; p < 3; p++) begin
      cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0, 1, 1, 0);
      idle(3);
    end
    chk("step_count3", cnt, 3);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);   // step held for two cycles
    cyc(0, 0, 1, 0, 0, 0, 1, 1, 0);
    idle(2);
    chk("step_held_count", cnt, 4);

    // Step-mode drain: HALT accepted in STEP_EXEC, DONE after 4 further steps
    done_q.push_back(9);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 1, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
      if (k < 4) chk("step_not_done", state, 2);
    end
    chk("step_drain_done", state, 5);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);

    // Reset mid-drain, then a normal run
    go(0);
    run_n(2);
    cyc(0, 0, 0, 1, 0, 0, 1, 1, 0);
    drain_n(1);
    rst = 1'b0;
    drain_n(1);
    rst = 1'b1;
    m_cnt = 0;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_en_pipe", en_pipe, 0);
    chk("mid_rst_en_pc", en_pc, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_count", cnt, 0);
    go(0);
    run_n(2);
    done_q.push_back(7);
    cyc(0, 0, 0, 1, 0, 0, 1, 1, 0);
    drain_n(4);
    chk("post_rst_done", state, 5);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);

    // Saturation on the 4-bit counter instance
    go(0);
    run_n(20);
    done_q.push_back(25);
    cyc(0, 0, 0, 1, 0, 0, 1, 1, 0);
    drain_n(4);
    chk("sat_done", s_done, 1);
    chk("sat_count", s_cnt, 15);
    chk("wide_count", cnt, 25);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(2);
    chk("sat_ack_state", s_state, 0);
    chk("sat_ack_done", s_done, 0);
    chk("sat_count_held", s_cnt, 15);

    idle(2);
    chk("adv_q_empty", adv_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
